sys_arr_sequencer: RTL and testbench

Job-level controller for the DSP systolic array. It clears the PE accumulators and the dispatcher, and lets the dispatcher stream one M×N by N×K job from the input FIFO. It then waits a fixed drain interval for the last partial sums to settle and pushes the M×K results, row-major, into the output FIFO. It sits between the host/AXI-stream control logic and the dispatcher, PE array and output FIFO.

---
 rtl/sys_arr_sequencer_if.sv | 25 ++
 rtl/sys_arr_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sys_arr_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_arr_sequencer_if.sv
// Sequencer-side bundle toward the dispatcher, the PE array and the output FIFO.
// master = sequencer, slave = the datapath blocks it controls.
interface sys_arr_sequencer_if #(
    parameter int M = 2,
    parameter int K = 2
);
    logic                      done_dispatch;
    logic                      disp_clr;
    logic                      pe_clr;
    logic                      disp_en;
    logic [M-1:0][K-1:0][31:0] pe_res;
    logic                      out_full;
    logic                      out_push;
    logic [31:0]               out_dat;

    modport master (
        input  done_dispatch, pe_res, out_full,
        output disp_clr, pe_clr, disp_en, out_push, out_dat
    );

    modport slave (
        output done_dispatch, pe_res, out_full,
        input  disp_clr, pe_clr, disp_en, out_push, out_dat
    );
endinterface

// File: rtl/sys_arr_sequencer.sv
// Job-level controller for the systolic array: clear, dispatch, drain, collect M x K results.
// state    | meaning
// IDLE     | waiting for start, all strobes low
// CLEAR    | one cycle clearing dispatcher and PE accumulators
// DISPATCH | dispatcher streams operands, timeout counter runs
// DRAIN    | fixed wait for the last partial sums to settle
// COLLECT  | push results row-major into the output FIFO
// FINISH   | one-cycle done pulse, job counter increments
module sys_arr_sequencer #(
    parameter int M         = 2,
    parameter int N         = 3,
    parameter int K         = 2,
    parameter int DRAIN_CYC = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        i_start,
    input  logic                        i_abort,
    sys_arr_sequencer_if.master         bus,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic [15:0]                 o_jobs_done
);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int DW = $clog2(DRAIN_CYC) + 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(K - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    if (DRAIN_CYC < 1 || N < 1 || M < 1 || K < 1 || TIMEOUT < 2) begin : g_param_check
        $error("sys_arr_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DISPATCH,
        S_DRAIN,
        S_COLLECT,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [TW-1:0]   r_to_cnt;
    logic [DW-1:0]   r_drain_cnt;
    logic            r_disp_clr;
    logic            r_pe_clr;
    logic            r_disp_en;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [15:0]     r_jobs_done;

    logic            w_timeout;
    logic            w_push;
    logic [31:0]     w_dat;
    logic            w_disp_clr_nxt;
    logic            w_pe_clr_nxt;
    logic            w_disp_en_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_start_acc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort overrides every transition, including a timeout or the final push
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (i_start) w_state_nxt = S_CLEAR;
                S_CLEAR:    w_state_nxt = S_DISPATCH;
                S_DISPATCH: begin
                    if (bus.done_dispatch) begin
                        w_state_nxt = S_DRAIN;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_timeout   = 1'b1;
                    end
                end
                S_DRAIN:    if (r_drain_cnt == '0) w_state_nxt = S_COLLECT;
                S_COLLECT:  if (w_push && r_row == ROW_LAST && r_col == COL_LAST) w_state_nxt = S_FINISH;
                S_FINISH:   w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // registered strobes are decoded from the next state so they line up with it
    always_comb begin
        w_push = (r_state == S_COLLECT) && !bus.out_full && !i_abort;
        w_dat  = '0;
        if (r_state == S_COLLECT) begin
            w_dat = bus.pe_res[r_row][r_col];
        end
        w_disp_clr_nxt = i_abort || (w_state_nxt == S_CLEAR);
        w_pe_clr_nxt   = (w_state_nxt == S_CLEAR);
        w_disp_en_nxt  = (w_state_nxt == S_DISPATCH);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_done_nxt     = (w_state_nxt == S_FINISH);
        w_start_acc    = (r_state == S_IDLE) && i_start && !i_abort;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_to_cnt    <= '0;
            r_drain_cnt <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else if (i_abort) begin
            r_to_cnt    <= '0;
            r_drain_cnt <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else begin
            if (r_state == S_DISPATCH && w_state_nxt == S_DISPATCH) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (r_state == S_DISPATCH && w_state_nxt == S_DRAIN) begin
                r_drain_cnt <= DRAIN_LOAD;
            end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end

            if (r_state != S_COLLECT) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_push) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_disp_clr  <= 1'b0;
            r_pe_clr    <= 1'b0;
            r_disp_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_jobs_done <= '0;
        end else begin
            r_disp_clr <= w_disp_clr_nxt;
            r_pe_clr   <= w_pe_clr_nxt;
            r_disp_en  <= w_disp_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_done_nxt) begin
                r_jobs_done <= r_jobs_done + 16'd1;
            end
        end
    end

    assign bus.disp_clr = r_disp_clr;
    assign bus.pe_clr   = r_pe_clr;
    assign bus.disp_en  = r_disp_en;
    assign bus.out_push = w_push;
    assign bus.out_dat  = w_dat;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_jobs_done  = r_jobs_done;
endmodule

// File: tb/tb_sys_arr_sequencer.sv
// Scoreboard bench for sys_arr_sequencer: directed jobs, expected pushes queued at stimulus time.
module tb_sys_arr_sequencer;
    localparam int M         = 2;
    localparam int N         = 3;
    localparam int K         = 2;
    localparam int DRAIN_CYC = 8;
    localparam int TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] jobs_done;

    sys_arr_sequencer_if #(.M(M), .K(K)) bif ();

    sys_arr_sequencer #(
        .M(M), .N(N), .K(K), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_start     (start),
        .i_abort     (abort),
        .bus         (bif),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_jobs_done (jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          push_cycs[$];
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    int          t_start = 0;
    int          d0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int push_at(input int i);
        if (i < push_cycs.size()) return push_cycs[i] - t_start;
        return -1;
    endfunction

    // monitor: pops the scoreboard whenever the DUT pushes
    always @(negedge clk) begin
        if (bif.out_push === 1'b1) begin
            push_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL push_unexpected: out_dat=%0d with nothing expected", bif.out_dat);
            end else begin
                chk("push_dat", bif.out_dat, exp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input int a, input int b, input int c, input int d, input bit expect_all);
        bif.pe_res[0][0] = a;
        bif.pe_res[0][1] = b;
        bif.pe_res[1][0] = c;
        bif.pe_res[1][1] = d;
        push_cycs.delete();
        if (expect_all) begin
            exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        t_start = cyc;
    endtask

    task automatic dispatch(input int d);
        repeat (d) step();
        bif.done_dispatch = 1'b1;
        step();
        bif.done_dispatch = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: busy still high after %0d cycles", name, budget);
        end
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; abort = 1'b0;
        bif.done_dispatch = 1'b0; bif.out_full = 1'b0; bif.pe_res = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_disp_clr", bif.disp_clr, 0);
        chk("rst_pe_clr", bif.pe_clr, 0);
        chk("rst_disp_en", bif.disp_en, 0);
        chk("rst_out_push", bif.out_push, 0);
        chk("rst_out_dat", bif.out_dat, 0);
        chk("rst_jobs_done", jobs_done, 0);
        @(posedge clk); #1 nrst = 1'b1;
        step();

        // basic job: D=5, start edge to done = 1+5+8+4 edges
        set_res(1, 2, 3, 4, 1'b1);
        d0 = done_cnt;
        do_start();
        @(negedge clk);
        chk("clear_disp_clr", bif.disp_clr, 1);
        chk("clear_pe_clr", bif.pe_clr, 1);
        chk("clear_busy", busy, 1);
        chk("clear_disp_en", bif.disp_en, 0);
        step();
        chk("dispatch_disp_en", bif.disp_en, 1);
        chk("dispatch_pe_clr", bif.pe_clr, 0);
        repeat (4) step();
        bif.done_dispatch = 1'b1;
        step();
        bif.done_dispatch = 1'b0;
        chk("drain_disp_en", bif.disp_en, 0);
        wait_idle(40, "basic_idle");
        chk("basic_npush", push_cycs.size(), 4);
        chk("basic_first_push", push_at(0), 14);
        chk("basic_last_push", push_at(3), 17);
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_done_cyc", last_done_cyc - t_start, 18);
        chk("basic_jobs", jobs_done, 1);

        // backpressure on 2nd and 3rd COLLECT cycles
        set_res(5, 6, 7, 8, 1'b1);
        d0 = done_cnt;
        do_start();
        dispatch(5);
        repeat (9) step();
        bif.out_full = 1'b1;
        repeat (2) step();
        bif.out_full = 1'b0;
        wait_idle(40, "bp_idle");
        chk("bp_npush", push_cycs.size(), 4);
        chk("bp_push0", push_at(0), 14);
        chk("bp_push1", push_at(1), 17);
        chk("bp_push3", push_at(3), 19);
        chk("bp_done_cyc", last_done_cyc - t_start, 20);
        chk("bp_done_cnt", done_cnt - d0, 1);
        chk("bp_jobs", jobs_done, 2);

        // timeout after 16 DISPATCH cycles
        set_res(0, 0, 0, 0, 1'b0);
        d0 = done_cnt;
        do_start();
        repeat (16) step();
        chk("to_busy_before", busy, 1);
        chk("to_err_before", err, 0);
        step();
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_no_done", done_cnt - d0, 0);
        chk("to_jobs", jobs_done, 2);
        chk("to_npush", push_cycs.size(), 0);
        set_res(9, 10, 11, 12, 1'b1);
        do_start();
        @(negedge clk);
        chk("to_err_cleared", err, 0);
        dispatch(3);
        wait_idle(40, "to_next_idle");
        chk("to_next_done_cyc", last_done_cyc - t_start, 16);
        chk("to_next_jobs", jobs_done, 3);

        // abort in the third COLLECT cycle, after two pushes
        set_res(21, 22, 23, 24, 1'b0);
        exp_q.push_back(21); exp_q.push_back(22);
        d0 = done_cnt;
        do_start();
        dispatch(2);
        repeat (10) step();
        chk("ab_pushes_before", push_cycs.size(), 2);
        abort = 1'b1;
        @(negedge clk);
        chk("ab_no_push", bif.out_push, 0);
        step();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_disp_clr", bif.disp_clr, 1);
        repeat (3) step();
        chk("ab_pushes_after", push_cycs.size(), 2);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_jobs", jobs_done, 3);
        chk("ab_queue_empty", exp_q.size(), 0);
        set_res(31, 32, 33, 34, 1'b1);
        do_start();
        dispatch(2);
        wait_idle(40, "ab_next_idle");
        chk("ab_next_npush", push_cycs.size(), 4);
        chk("ab_next_jobs", jobs_done, 4);

        // start during DRAIN and start+abort in IDLE are ignored
        set_res(41, 42, 43, 44, 1'b1);
        do_start();
        dispatch(1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(40, "sd_idle");
        chk("sd_done_cyc", last_done_cyc - t_start, 14);
        chk("sd_jobs", jobs_done, 5);
        repeat (3) step();
        chk("sd_no_restart", busy, 0);
        d0 = done_cnt;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_disp_clr", bif.disp_clr, 1);
        chk("sa_pe_clr", bif.pe_clr, 0);
        step();
        chk("sa_busy_later", busy, 0);
        chk("sa_jobs", jobs_done, 5);
        chk("sa_no_done", done_cnt - d0, 0);

        // async reset in the middle of DISPATCH
        set_res(0, 0, 0, 0, 1'b0);
        do_start();
        repeat (3) step();
        chk("ar_busy_before", busy, 1);
        #2 nrst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_disp_en", bif.disp_en, 0);
        chk("ar_jobs", jobs_done, 0);
        @(posedge clk); #1 nrst = 1'b1;
        step();
        set_res(51, 52, 53, 54, 1'b1);
        do_start();
        dispatch(4);
        wait_idle(40, "b2b_a_idle");
        chk("b2b_jobs_1", jobs_done, 1);
        set_res(61, 62, 63, 64, 1'b1);
        do_start();
        dispatch(2);
        wait_idle(40, "b2b_b_idle");
        chk("b2b_jobs_2", jobs_done, 2);

        // counter wrap from 65535
        force dut.r_jobs_done = 16'hFFFF;
        @(negedge clk);
        chk("wrap_forced", jobs_done, 65535);
        release dut.r_jobs_done;
        step();
        set_res(71, 72, 73, 74, 1'b1);
        d0 = done_cnt;
        do_start();
        dispatch(1);
        wait_idle(40, "wrap_idle");
        chk("wrap_done_cnt", done_cnt - d0, 1);
        chk("wrap_jobs", jobs_done, 0);

        repeat (2) step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
